// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between NUM_REQ requesters
// and registers its result into a single valid/ready response channel tagged with requester id.
module alu_share_arbiter #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REQ   = 3,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    // control = {op1_sel[1:0], op2_sel[1:0], operation[3:0], use_unsigned}; all-zero = OP_ZERO/OP_ZERO/OP_ADD
    localparam int CTRL_W   = 9
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [NUM_REQ-1:0]                   i_req_valid,
    output logic [NUM_REQ-1:0]                   o_req_ready,
    input  logic [NUM_REQ-1:0][CTRL_W-1:0]       i_req_control,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]    i_req_rs1,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]    i_req_rs2,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]    i_req_imm,
    input  logic [NUM_REQ-1:0][REG_WIDTH-1:0]    i_req_pc,
    output logic [CTRL_W-1:0]                    o_alu_control,
    output logic [REG_WIDTH-1:0]                 o_alu_rs1,
    output logic [REG_WIDTH-1:0]                 o_alu_rs2,
    output logic [REG_WIDTH-1:0]                 o_alu_imm,
    output logic [REG_WIDTH-1:0]                 o_alu_pc,
    input  logic [REG_WIDTH-1:0]                 i_alu_result,
    input  logic                                 i_alu_zero,
    input  logic                                 i_alu_less_than,
    output logic                                 o_rsp_valid,
    input  logic                                 i_rsp_ready,
    output logic [ID_W-1:0]                      o_rsp_id,
    output logic [REG_WIDTH-1:0]                 o_rsp_result,
    output logic                                 o_rsp_zero,
    output logic                                 o_rsp_less_than
);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [REG_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                 rsp_zero_q, rsp_zero_d;
    logic                 rsp_lt_q, rsp_lt_d;

    logic                 can_issue;
    logic                 gnt_vld;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W:0]        cand;

    assign can_issue = (state_q == S_EMPTY) || i_rsp_ready;

    // First valid requester at or after rr_ptr, wrapping; suppressed while reset is held.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (can_issue && !i_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
                if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
                if (!gnt_vld && i_req_valid[cand[ID_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        o_req_ready   = '0;
        o_alu_control = '0;
        o_alu_rs1     = '0;
        o_alu_rs2     = '0;
        o_alu_imm     = '0;
        o_alu_pc      = '0;
        if (gnt_vld) begin
            o_req_ready[gnt_idx] = 1'b1;
            o_alu_control        = i_req_control[gnt_idx];
            o_alu_rs1            = i_req_rs1[gnt_idx];
            o_alu_rs2            = i_req_rs2[gnt_idx];
            o_alu_imm            = i_req_imm[gnt_idx];
            o_alu_pc             = i_req_pc[gnt_idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_lt_d     = rsp_lt_q;
        if (gnt_vld) begin
            rr_ptr_d     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + ID_W'(1);
            rsp_id_d     = gnt_idx;
            rsp_result_d = i_alu_result;
            rsp_zero_d   = i_alu_zero;
            rsp_lt_d     = i_alu_less_than;
        end
        case (state_q)
            S_EMPTY: if (gnt_vld) state_d = S_FULL;
            S_FULL:  if (i_rsp_ready && !gnt_vld) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_EMPTY;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_lt_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_lt_q     <= rsp_lt_d;
        end
    end

    assign o_rsp_valid     = (state_q == S_FULL);
    assign o_rsp_id        = rsp_id_q;
    assign o_rsp_result    = rsp_result_q;
    assign o_rsp_zero      = rsp_zero_q;
    assign o_rsp_less_than = rsp_lt_q;

endmodule
